// File: rtl/dstack_spill.sv
// Spill store for the bottom of the data stack: a small circular deque in front of a memory spill region.
// Evicted words are drained oldest-first to memory and returned newest-first when the dstack runs dry.
`timescale 1ns/1ps
module dstack_spill #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BUF_MAG     = 2,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic                   spill_valid,
    input  logic [WIDTH-1:0]       spill_data,
    output logic                   spill_ready,
    input  logic                   fill_req,
    output logic                   fill_valid,
    output logic [WIDTH-1:0]       fill_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    input  logic                   mem_ack,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic [COUNT_WIDTH-1:0] mem_count,
    output logic                   empty,
    output logic                   fault
);

    localparam int unsigned DEPTH = 1 << BUF_MAG;

    typedef logic [BUF_MAG-1:0]     ptr_t;
    typedef logic [BUF_MAG:0]       cnt_t;
    typedef logic [COUNT_WIDTH-1:0] mcnt_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    localparam ptr_t  PTR_ONE  = ptr_t'(1);
    localparam cnt_t  CNT_ONE  = cnt_t'(1);
    localparam cnt_t  CNT_FULL = cnt_t'(DEPTH);
    localparam mcnt_t MCNT_ONE = mcnt_t'(1);
    localparam addr_t ADDR_ONE = addr_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] slots [DEPTH];
    ptr_t  tail, tail_d;
    cnt_t  count, count_d;
    mcnt_t mcount, mcount_d;
    logic  pend, pend_d;

    logic             fill_valid_d;
    logic [WIDTH-1:0] fill_data_d;
    logic             fault_d;
    logic             mem_we_d;
    addr_t            mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_d;

    ptr_t  head;
    ptr_t  push_at;
    addr_t mcount_addr;
    logic  dq_empty;
    logic  all_empty;
    logic  accept;
    logic  bypass;
    logic  fill_new;
    logic  want_fill;
    logic  servable;
    logic  pop_head;
    logic  pop_tail;

    // head = newest entry, tail = oldest; push lands just above the head
    assign head        = tail + count[BUF_MAG-1:0] - PTR_ONE;
    assign push_at     = tail + count[BUF_MAG-1:0];
    assign mcount_addr = addr_t'(mcount);
    assign dq_empty    = (count == '0);
    assign all_empty   = dq_empty && (mcount == '0);

    assign spill_ready = (count != CNT_FULL);
    assign empty       = all_empty;
    assign mem_req     = (state != IDLE);
    assign mem_count   = mcount;

    assign bypass    = spill_valid && fill_req && !pend;
    assign accept    = spill_valid && spill_ready && !bypass;
    assign fill_new  = fill_req && !pend && !spill_valid && !all_empty;
    assign want_fill = fill_new || pend;
    // During a write the tail entry is in flight and must not be handed back
    assign servable  = ((state == IDLE) && !dq_empty) || ((state == WRITE) && (count > CNT_ONE));
    assign pop_head  = want_fill && servable;
    assign pop_tail  = (state == WRITE) && mem_ack;

    always_comb begin
        state_d      = state;
        pend_d       = pend;
        count_d      = count;
        tail_d       = tail;
        mcount_d     = mcount;
        fill_valid_d = 1'b0;
        fill_data_d  = fill_data;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        fault_d      = (spill_valid && !spill_ready && !bypass)
                    || (fill_req && pend)
                    || (fill_req && !pend && !spill_valid && all_empty);

        if (accept) begin
            count_d = count_d + CNT_ONE;
        end
        if (pop_head) begin
            count_d = count_d - CNT_ONE;
        end
        if (pop_tail) begin
            count_d = count_d - CNT_ONE;
            tail_d  = tail + PTR_ONE;
        end

        if (bypass) begin
            fill_valid_d = 1'b1;
            fill_data_d  = spill_data;
        end else if (pop_head) begin
            fill_valid_d = 1'b1;
            fill_data_d  = slots[head];
        end

        if (pop_head) begin
            pend_d = 1'b0;
        end else if (fill_new) begin
            pend_d = 1'b1;
        end

        case (state)
            IDLE: begin
                if (want_fill && !pop_head) begin
                    if (mcount != '0) begin
                        state_d    = READ;
                        mem_we_d   = 1'b0;
                        mem_addr_d = base_addr + mcount_addr - ADDR_ONE;
                    end
                end else if (!want_fill && !dq_empty && (mcount != '1)) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_addr + mcount_addr;
                    mem_wdata_d = slots[tail];
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    mcount_d = mcount + MCNT_ONE;
                end
            end
            READ: begin
                if (mem_ack) begin
                    state_d      = IDLE;
                    mcount_d     = mcount - MCNT_ONE;
                    pend_d       = 1'b0;
                    fill_valid_d = 1'b1;
                    fill_data_d  = mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tail       <= '0;
            count      <= '0;
            mcount     <= '0;
            pend       <= 1'b0;
            fill_valid <= 1'b0;
            fill_data  <= '0;
            fault      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            tail       <= tail_d;
            count      <= count_d;
            mcount     <= mcount_d;
            pend       <= pend_d;
            fill_valid <= fill_valid_d;
            fill_data  <= fill_data_d;
            fault      <= fault_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slots[push_at] <= spill_data;
        end
    end

endmodule

// File: tb/tb_dstack_spill.sv
// Directed bench for dstack_spill: spill/drain, memory fills, deque fills, bypass, overflow and reset.
`timescale 1ns/1ps
module tb_dstack_spill;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BUF_MAG     = 2;
    localparam int unsigned COUNT_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic                   spill_valid;
    logic [WIDTH-1:0]       spill_data;
    logic                   spill_ready;
    logic                   fill_req;
    logic                   fill_valid;
    logic [WIDTH-1:0]       fill_data;
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [WIDTH-1:0]       mem_wdata;
    logic                   mem_ack;
    logic [WIDTH-1:0]       mem_rdata;
    logic [COUNT_WIDTH-1:0] mem_count;
    logic                   empty;
    logic                   fault;

    logic ack_en;

    dstack_spill #(
        .WIDTH       (WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BUF_MAG     (BUF_MAG),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .base_addr   (base_addr),
        .spill_valid (spill_valid),
        .spill_data  (spill_data),
        .spill_ready (spill_ready),
        .fill_req    (fill_req),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_count   (mem_count),
        .empty       (empty),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Memory model: same-cycle ack when enabled, small array indexed by low address bits
    logic [WIDTH-1:0]      tb_mem [256];
    logic [ADDR_WIDTH-1:0] wr_addr [8];
    logic [WIDTH-1:0]      wr_data [8];
    logic [ADDR_WIDTH-1:0] last_rd = '0;
    int unsigned           n_wr = 0;

    assign mem_ack   = ack_en && mem_req;
    assign mem_rdata = tb_mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                tb_mem[mem_addr[7:0]] <= mem_wdata;
                if (n_wr < 8) begin
                    wr_addr[n_wr[2:0]] <= mem_addr;
                    wr_data[n_wr[2:0]] <= mem_wdata;
                end
                n_wr <= n_wr + 1;
            end else begin
                last_rd <= mem_addr;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [WIDTH-1:0] abc [3];
    logic [WIDTH-1:0] wv  [4];
    logic             got;

    initial begin
        abc[0] = 32'hAAAA_0001;
        abc[1] = 32'hBBBB_0002;
        abc[2] = 32'hCCCC_0003;
        wv[0]  = 32'h1000_0000;
        wv[1]  = 32'h1111_1111;
        wv[2]  = 32'h2222_2222;
        wv[3]  = 32'h3333_3333;

        reset_n     = 1'b0;
        base_addr   = 32'h0000_0100;
        spill_valid = 1'b0;
        spill_data  = '0;
        fill_req    = 1'b0;
        ack_en      = 1'b0;
        nclk(2);

        chk("rst_spill_ready", 64'(spill_ready), 64'(1));
        chk("rst_empty",       64'(empty),       64'(1));
        chk("rst_mem_req",     64'(mem_req),     64'(0));
        chk("rst_fill_valid",  64'(fill_valid),  64'(0));
        chk("rst_fault",       64'(fault),       64'(0));
        chk("rst_mem_count",   64'(mem_count),   64'(0));
        chk("rst_fill_data",   64'(fill_data),   64'(0));
        chk("rst_mem_we",      64'(mem_we),      64'(0));
        chk("rst_mem_addr",    64'(mem_addr),    64'(0));
        reset_n = 1'b1;
        nclk(1);

        // Three spills drained to base, base+1, base+2
        ack_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            spill_valid = 1'b1;
            spill_data  = abc[i];
            nclk(1);
        end
        spill_valid = 1'b0;
        nclk(8);
        chk("drain_mem_count", 64'(mem_count), 64'(3));
        chk("drain_empty",     64'(empty),     64'(0));
        chk("drain_n_wr",      64'(n_wr),      64'(3));
        for (int i = 0; i < 3; i++) begin
            chk("drain_wr_addr", 64'(wr_addr[i]), 64'(32'h100 + i));
            chk("drain_wr_data", 64'(wr_data[i]), 64'(abc[i]));
        end

        // Fills come back newest-first from memory
        for (int i = 0; i < 3; i++) begin
            fill_req = 1'b1;
            nclk(1);
            fill_req = 1'b0;
            chk("rd_mem_req",  64'(mem_req),  64'(1));
            chk("rd_mem_we",   64'(mem_we),   64'(0));
            chk("rd_mem_addr", 64'(mem_addr), 64'(32'h102 - i));
            nclk(1);
            chk("rd_fill_valid", 64'(fill_valid), 64'(1));
            chk("rd_fill_data",  64'(fill_data),  64'(abc[2-i]));
            nclk(2);
        end
        chk("rd_empty",       64'(empty),      64'(1));
        chk("rd_mem_count",   64'(mem_count),  64'(0));
        chk("rd_fill_pulse",  64'(fill_valid), 64'(0));

        // Fill while completely empty
        fill_req = 1'b1;
        nclk(1);
        fill_req = 1'b0;
        chk("efill_fault",      64'(fault),      64'(1));
        chk("efill_fill_valid", 64'(fill_valid), 64'(0));
        chk("efill_mem_req",    64'(mem_req),    64'(0));
        nclk(1);
        chk("efill_fault_pulse", 64'(fault), 64'(0));

        // Overflow with memory stalled
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spill_valid = 1'b1;
            spill_data  = wv[i];
            nclk(1);
        end
        chk("full_spill_ready", 64'(spill_ready), 64'(0));
        spill_data = 32'h4444_4444;
        nclk(1);
        spill_valid = 1'b0;
        chk("full_fault",     64'(fault),     64'(1));
        chk("full_mem_req",   64'(mem_req),   64'(1));
        chk("full_mem_we",    64'(mem_we),    64'(1));
        chk("full_mem_addr",  64'(mem_addr),  64'(32'h100));
        chk("full_mem_wdata", 64'(mem_wdata), 64'(wv[0]));
        nclk(1);
        chk("full_fault_pulse", 64'(fault),       64'(0));
        chk("full_still_full",  64'(spill_ready), 64'(0));
        ack_en = 1'b1;
        nclk(10);
        chk("full_mem_count",   64'(mem_count),   64'(4));
        chk("full_ready_again", 64'(spill_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            fill_req = 1'b1;
            nclk(1);
            fill_req = 1'b0;
            chk("full_rd_addr", 64'(mem_addr), 64'(32'h103 - i));
            nclk(1);
            chk("full_rd_valid", 64'(fill_valid), 64'(1));
            chk("full_rd_data",  64'(fill_data),  64'(wv[3-i]));
            nclk(2);
        end
        chk("full_rd_empty", 64'(empty), 64'(1));

        // Fill requested while the only word is an unacknowledged write
        ack_en      = 1'b0;
        spill_valid = 1'b1;
        spill_data  = 32'h5A5A_5A5A;
        nclk(1);
        spill_valid = 1'b0;
        nclk(1);
        chk("inflt_mem_we",    64'(mem_we),    64'(1));
        chk("inflt_mem_addr",  64'(mem_addr),  64'(32'h100));
        chk("inflt_mem_wdata", 64'(mem_wdata), 64'(32'h5A5A_5A5A));
        fill_req = 1'b1;
        nclk(1);
        fill_req = 1'b0;
        chk("inflt_no_fill",  64'(fill_valid), 64'(0));
        chk("inflt_no_fault", 64'(fault),      64'(0));
        nclk(2);
        chk("inflt_wait_fill", 64'(fill_valid), 64'(0));
        chk("inflt_wait_req",  64'(mem_req),    64'(1));
        ack_en = 1'b1;
        got    = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            nclk(1);
            if (fill_valid) got = 1'b1;
        end
        chk("inflt_fill_seen", 64'(got),       64'(1));
        chk("inflt_fill_data", 64'(fill_data), 64'(32'h5A5A_5A5A));
        chk("inflt_rd_addr",   64'(last_rd),   64'(32'h100));
        chk("inflt_mem_count", 64'(mem_count), 64'(0));
        chk("inflt_empty",     64'(empty),     64'(1));

        // Bypass: simultaneous spill and fill never touch deque or memory
        spill_valid = 1'b1;
        spill_data  = 32'h7777_0007;
        nclk(1);
        spill_valid = 1'b0;
        nclk(4);
        chk("byp_pre_count", 64'(mem_count), 64'(1));
        spill_valid = 1'b1;
        spill_data  = 32'hD00D_F00D;
        fill_req    = 1'b1;
        nclk(1);
        spill_valid = 1'b0;
        fill_req    = 1'b0;
        chk("byp_fill_valid", 64'(fill_valid), 64'(1));
        chk("byp_fill_data",  64'(fill_data),  64'(32'hD00D_F00D));
        chk("byp_mem_count",  64'(mem_count),  64'(1));
        chk("byp_no_fault",   64'(fault),      64'(0));
        nclk(1);
        chk("byp_no_write", 64'(mem_req),    64'(0));
        chk("byp_pulse",    64'(fill_valid), 64'(0));
        chk("byp_count2",   64'(mem_count),  64'(1));

        // Fill served from the deque head while the tail write is outstanding
        ack_en      = 1'b0;
        spill_valid = 1'b1;
        spill_data  = 32'hAB00_0001;
        nclk(1);
        spill_data  = 32'hAB00_0002;
        nclk(1);
        spill_valid = 1'b0;
        chk("dq_mem_we",   64'(mem_we),   64'(1));
        chk("dq_mem_addr", 64'(mem_addr), 64'(32'h101));
        fill_req = 1'b1;
        nclk(1);
        fill_req = 1'b0;
        chk("dq_fill_valid", 64'(fill_valid), 64'(1));
        chk("dq_fill_data",  64'(fill_data),  64'(32'hAB00_0002));
        chk("dq_wdata_held", 64'(mem_wdata),  64'(32'hAB00_0001));
        ack_en = 1'b1;
        nclk(1);
        ack_en = 1'b0;
        chk("dq_mem_count", 64'(mem_count), 64'(2));
        chk("dq_idle",      64'(mem_req),   64'(0));

        // Reset in the middle of a read
        fill_req = 1'b1;
        nclk(1);
        fill_req = 1'b0;
        chk("rst_rd_req",  64'(mem_req),  64'(1));
        chk("rst_rd_addr", 64'(mem_addr), 64'(32'h101));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_req_drop", 64'(mem_req), 64'(0));
        nclk(1);
        reset_n = 1'b1;
        nclk(1);
        chk("rst2_mem_count",  64'(mem_count),   64'(0));
        chk("rst2_empty",      64'(empty),       64'(1));
        chk("rst2_ready",      64'(spill_ready), 64'(1));
        chk("rst2_fill_valid", 64'(fill_valid),  64'(0));
        chk("rst2_mem_req",    64'(mem_req),     64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
